hazard_scoreboard: RTL

- Tracks in-flight destination-register writes for the 5-stage pipeline (IF/ID/EX/MEM/WB). It holds one slot each for the EX, MEM and WB stages.
- Produces the exmem/memwb rd and regWrite signals consumed by the forwarding unit.
- Detects load-use hazards that forwarding cannot cover, and drives the front-end stall, bubble-insert and write-enable controls.
- Counts load-use stall cycles for performance debug.

---
 rtl/hazard_scoreboard.sv | 113 +++++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// Load-use hazard scoreboard for a 5-stage pipeline: tracks EX/MEM/WB destination
// writes, feeds the forwarding unit, and drives stall/bubble controls plus a stall counter.
module hazard_scoreboard #(
   parameter int unsigned REG_BITS  = 3,
   parameter int unsigned CNT_WIDTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       id_valid,
   input  logic [REG_BITS-1:0]        id_rs,
   input  logic [REG_BITS-1:0]        id_rt,
   input  logic                       id_rs_used,
   input  logic                       id_rt_used,
   input  logic [REG_BITS-1:0]        id_rd,
   input  logic                       id_regWrite,
   input  logic                       id_memRead,
   input  logic                       flush,
   input  logic                       mem_busy,
   output logic [REG_BITS-1:0]        exmem_rd,
   output logic                       exmem_regWrite,
   output logic [REG_BITS-1:0]        memwb_rd,
   output logic                       memwb_regWrite,
   output logic [(1<<REG_BITS)-1:0]   busy,
   output logic                       stall,
   output logic                       pc_write_en,
   output logic                       ifid_write_en,
   output logic                       idex_bubble,
   output logic [CNT_WIDTH-1:0]       stall_count
);

   localparam int unsigned NREGS = 1 << REG_BITS;

   typedef struct packed {
      logic                v;
      logic [REG_BITS-1:0] rd;
      logic                wr;
      logic                ld;
   } slot_t;

   // The load flag is never consulted once an entry leaves MEM, so WB drops it.
   typedef struct packed {
      logic                v;
      logic [REG_BITS-1:0] rd;
      logic                wr;
   } wb_slot_t;

   slot_t                ex_q,  ex_d;
   slot_t                mem_q, mem_d;
   wb_slot_t             wb_q,  wb_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

   logic rs_hit, rt_hit, hz, issue;

   always_comb begin
      rs_hit = id_rs_used & (id_rs == ex_q.rd);
      rt_hit = id_rt_used & (id_rt == ex_q.rd);
      hz     = id_valid & ~flush & ex_q.v & ex_q.wr & ex_q.ld & (rs_hit | rt_hit);
      issue  = id_valid & ~hz & ~flush;
   end

   assign stall          = hz | mem_busy;
   assign pc_write_en    = ~stall;
   assign ifid_write_en  = ~stall;
   assign idex_bubble    = (hz | flush) & ~mem_busy;

   assign exmem_rd       = mem_q.rd;
   assign exmem_regWrite = mem_q.v & mem_q.wr;
   assign memwb_rd       = wb_q.rd;
   assign memwb_regWrite = wb_q.v & wb_q.wr;
   assign stall_count    = cnt_q;

   always_comb begin
      busy = '0;
      for (int unsigned i = 0; i < NREGS; i++) begin
         if (ex_q.v  && ex_q.wr  && ex_q.rd  == REG_BITS'(i)) busy[i] = 1'b1;
         if (mem_q.v && mem_q.wr && mem_q.rd == REG_BITS'(i)) busy[i] = 1'b1;
         if (wb_q.v  && wb_q.wr  && wb_q.rd  == REG_BITS'(i)) busy[i] = 1'b1;
      end
   end

   always_comb begin
      ex_d  = ex_q;
      mem_d = mem_q;
      wb_d  = wb_q;
      cnt_d = cnt_q;
      if (!mem_busy) begin
         wb_d  = '{v: mem_q.v, rd: mem_q.rd, wr: mem_q.wr};
         mem_d = ex_q;
         ex_d  = '0;
         if (issue) begin
            ex_d = '{v: 1'b1, rd: id_rd, wr: id_regWrite, ld: id_memRead};
         end
         if (hz && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
         cnt_q <= '0;
      end else begin
         ex_q  <= ex_d;
         mem_q <= mem_d;
         wb_q  <= wb_d;
         cnt_q <= cnt_d;
      end
   end

endmodule
